// File: rtl/verdict_stream_serializer_pkg.sv
// Shared widths, frame-entry layout and word-building helpers for the verdict stream serializer.
package verdict_stream_serializer_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned TS_W   = 64;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned MASK_W = 16;

  localparam int unsigned HdrMaskLsb = 0;
  localparam int unsigned HdrDropLsb = 16;
  localparam int unsigned HdrSeqLsb  = 48;

  // ts is the most significant field so it sits at the top of a packed entry.
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [SEQ_W-1:0]  seq;
    logic [DROP_W-1:0] drop;
    logic [MASK_W-1:0] aktv;
  } frame_meta_t;

  function automatic logic [WORD_W-1:0] header_word(frame_meta_t m);
    logic [WORD_W-1:0] w;
    w = '0;
    w[HdrMaskLsb +: MASK_W] = m.aktv;
    w[HdrDropLsb +: DROP_W] = m.drop;
    w[HdrSeqLsb +: SEQ_W]   = m.seq;
    return w;
  endfunction

  function automatic logic [3:0] lowest_set(logic [MASK_W-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/verdict_frame_fifo.sv
// Synchronous first-word-fall-through FIFO of frame entries; exposes head and the entry behind it.
module verdict_frame_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [Width-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned LvlW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      level_q <= level_d;
      full_q  <= (level_d == LvlW'(Depth));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/verdict_stream_serializer.sv
// Captures cycles with active monitor outputs as timestamped frames and serialises them as
// a ready/valid stream of 64-bit words: timestamp, header, then one word per active stream.
module verdict_stream_serializer
  import verdict_stream_serializer_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 9,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [NUM_OUTPUTS*DATA_W-1:0]   out_vals_i,
  input  logic [NUM_OUTPUTS-1:0]          out_aktv_i,
  output logic [WORD_W-1:0]               m_data_o,
  output logic                            m_valid_o,
  output logic                            m_last_o,
  input  logic                            m_ready_i,
  output logic                            overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam int unsigned LvlW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ValsW  = NUM_OUTPUTS * DATA_W;
  localparam int unsigned MetaW  = $bits(frame_meta_t);
  localparam int unsigned EntryW = MetaW + ValsW;

  typedef enum logic [1:0] {StIdle, StTs, StHdr, StData} state_e;

  function automatic logic [WORD_W-1:0] val_word(logic [ValsW-1:0] vals, logic [3:0] idx);
    logic signed [DATA_W-1:0] v;
    int unsigned              base;
    base = 32'(idx) * DATA_W;
    v    = vals[base +: DATA_W];
    return WORD_W'(v);
  endfunction

  logic [TS_W-1:0]   ts_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [DROP_W-1:0] drop_q;
  logic              overflow_q;

  state_e            state_q;
  logic [WORD_W-1:0] m_data_q;
  logic              m_valid_q, m_last_q;
  logic [MASK_W-1:0] rem_q;

  logic              capture, fifo_full, fifo_empty, pop, xfer;
  logic [LvlW-1:0]   fifo_level;
  frame_meta_t       wr_meta, head_meta;
  logic [EntryW-1:0] wr_entry, head_entry, next_entry;
  logic [ValsW-1:0]  head_vals;
  logic [TS_W-1:0]   next_ts;
  logic [MASK_W-1:0] sel_mask, sel_rest;
  logic [3:0]        sel_idx;
  logic              unused_next;

  assign capture = en_i && (|out_aktv_i);

  always_comb begin
    wr_meta      = '0;
    wr_meta.ts   = ts_q;
    wr_meta.seq  = seq_q;
    wr_meta.drop = drop_q;
    wr_meta.aktv = MASK_W'(out_aktv_i);
  end
  assign wr_entry = {wr_meta, out_vals_i};

  // Drops use the registered full flag, so a same-cycle pop never rescues a capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (en_i) ts_q <= ts_q + TS_W'(1);
      if (capture && !fifo_full) begin
        seq_q  <= seq_q + SEQ_W'(1);
        drop_q <= '0;
      end else if (capture) begin
        if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
        overflow_q <= 1'b1;
      end
    end
  end

  verdict_frame_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (capture),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .next_o  (next_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign head_meta   = head_entry[EntryW-1 -: MetaW];
  assign head_vals   = head_entry[ValsW-1:0];
  assign next_ts     = next_entry[EntryW-1 -: TS_W];
  assign unused_next = ^next_entry;

  assign xfer     = m_valid_q && m_ready_i;
  assign pop      = (state_q == StData) && xfer && (rem_q == '0);
  assign sel_mask = (state_q == StHdr) ? head_meta.aktv : rem_q;
  assign sel_idx  = lowest_set(sel_mask);
  assign sel_rest = sel_mask & ~(MASK_W'(1) << sel_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      rem_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q   <= StTs;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            m_data_q  <= head_meta.ts;
          end
        end
        StTs: begin
          if (xfer) begin
            state_q  <= StHdr;
            m_data_q <= header_word(head_meta);
          end
        end
        StHdr: begin
          if (xfer) begin
            state_q  <= StData;
            m_data_q <= val_word(head_vals, sel_idx);
            rem_q    <= sel_rest;
            m_last_q <= (sel_rest == '0);
          end
        end
        StData: begin
          if (xfer) begin
            if (rem_q != '0) begin
              m_data_q <= val_word(head_vals, sel_idx);
              rem_q    <= sel_rest;
              m_last_q <= (sel_rest == '0);
            end else if (fifo_level > LvlW'(1)) begin
              // Entry behind the head is already stored: start it without a bubble.
              state_q  <= StTs;
              m_data_q <= next_ts;
              m_last_q <= 1'b0;
            end else begin
              state_q   <= StIdle;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_verdict_stream_serializer.sv
// Scoreboard bench: a frame model pushes expected words on capture, the monitor pops on transfer.
module tb_verdict_stream_serializer;

  localparam int unsigned NO    = 9;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              m_ready = 1'b1;
  logic [NO*DW-1:0]  vals = '0;
  logic [NO-1:0]     aktv = '0;
  logic [63:0]       m_data;
  logic              m_valid, m_last, overflow;
  logic [3:0]        fifo_level;

  always #5 clk = ~clk;

  verdict_stream_serializer #(
    .NUM_OUTPUTS (NO),
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .out_vals_i   (vals),
    .out_aktv_i   (aktv),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_last_o     (m_last),
    .m_ready_i    (m_ready),
    .overflow_o   (overflow),
    .fifo_level_o (fifo_level)
  );

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
  endtask

  // Expected words: bit 64 is m_last.
  logic [64:0] sb[$];
  logic [63:0] mts = '0;
  logic [15:0] mseq = '0, mdrop = '0;
  int          mlevel = 0;
  logic        movf = 1'b0;
  bit          mon_en = 0, prev_stall = 0;
  int          widx = 0;
  logic [63:0] last_w0 = '0, last_hdr = '0;

  task automatic push_frame();
    int unsigned remaining;
    logic signed [DW-1:0] sv;
    remaining = $countones(aktv);
    sb.push_back({1'b0, mts});
    sb.push_back({1'b0, mseq, 16'h0, mdrop, 16'(aktv)});
    for (int i = 0; i < NO; i++) begin
      if (aktv[i]) begin
        remaining--;
        sv = vals[i*DW +: DW];
        sb.push_back({remaining == 0, 64'(sv)});
      end
    end
  endtask

  // Each negedge predicts what the coming posedge does, after checking the DUT's current state.
  always @(negedge clk) begin
    logic [64:0] exp;
    bit last_xfer;
    if (mon_en) begin
      if (rst) begin
        sb.delete();
        mts = '0; mseq = '0; mdrop = '0; mlevel = 0; movf = 1'b0;
        prev_stall = 0; widx = 0;
      end else begin
        last_xfer = 0;
        check_eq("fifo_level", 64'(fifo_level), 64'(mlevel));
        check_eq("overflow", 64'(overflow), 64'(movf));
        if (prev_stall) check_eq("valid_held", 64'(m_valid), 64'd1);
        if (m_valid) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_valid", 64'(m_valid), 64'd0);
          end else begin
            exp = sb[0];
            check_eq("word_data", m_data, exp[63:0]);
            check_eq("word_last", 64'(m_last), 64'(exp[64]));
            if (m_ready) begin
              void'(sb.pop_front());
              if (widx == 0) last_w0 = m_data;
              if (widx == 1) last_hdr = m_data;
              if (exp[64]) begin
                widx = 0;
                last_xfer = 1;
              end else begin
                widx++;
              end
            end
          end
        end
        prev_stall = m_valid && !m_ready;
        if (en && aktv != '0) begin
          if (mlevel == DEPTH) begin
            if (mdrop != 16'hFFFF) mdrop++;
            movf = 1'b1;
          end else begin
            push_frame();
            mseq++;
            mdrop = '0;
            mlevel++;
          end
        end
        if (last_xfer) mlevel--;
        if (en) mts++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_val(input int i, input logic [63:0] v);
    vals[i*DW +: DW] = v;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (sb.size() == 0 && !m_valid) done = 1;
    end
    check_eq("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    step();
    mon_en = 1;
    do_reset();
    check_eq("rst_valid", 64'(m_valid), 64'd0);
    check_eq("rst_data", m_data, 64'd0);
    check_eq("rst_level", 64'(fifo_level), 64'd0);

    // 1: single frame, latency and content
    en = 1'b1;
    repeat (10) step();
    set_val(0, 64'd7);
    set_val(2, -64'sd3);
    aktv = 9'b000000101;
    step();
    aktv = '0;
    @(negedge clk) check_eq("t1_lat_pre", 64'(m_valid), 64'd0);
    @(negedge clk) check_eq("t1_lat_valid", 64'(m_valid), 64'd1);
    check_eq("t1_w0", m_data, 64'd10);
    wait_idle(40);
    check_eq("t1_w0_seen", last_w0, 64'd10);
    check_eq("t1_hdr", last_hdr, 64'h0000_0000_0000_0005);

    // 2: backpressure on the header word
    aktv = 9'b000000101;
    step();
    aktv = '0;
    step();
    step();
    m_ready = 1'b0;
    repeat (5) begin
      step();
      check_eq("t2_hold_valid", 64'(m_valid), 64'd1);
      check_eq("t2_hold_hdr", m_data, 64'h0001_0000_0000_0005);
      check_eq("t2_hold_last", 64'(m_last), 64'd0);
    end
    m_ready = 1'b1;
    wait_idle(40);

    // 3: full mask, eleven words
    for (int i = 0; i < NO; i++) set_val(i, 64'(i + 1));
    aktv = 9'h1FF;
    step();
    aktv = '0;
    wait_idle(60);
    check_eq("t3_hdr_mask", 64'(last_hdr[15:0]), 64'h1FF);

    // 4: overflow with a stalled sink
    do_reset();
    en = 1'b1;
    m_ready = 1'b0;
    set_val(0, 64'h1234);
    aktv = 9'b000000001;
    repeat (10) step();
    aktv = '0;
    check_eq("t4_level", 64'(fifo_level), 64'd8);
    check_eq("t4_overflow", 64'(overflow), 64'd1);
    m_ready = 1'b1;
    wait_idle(200);
    aktv = 9'b000000001;
    step();
    aktv = '0;
    wait_idle(40);
    check_eq("t4_seq", 64'(last_hdr[63:48]), 64'd8);
    check_eq("t4_drop", 64'(last_hdr[31:16]), 64'd2);
    check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);

    // 5: enable low freezes timestamp and blocks capture
    do_reset();
    en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    aktv = 9'b000000001;
    repeat (4) step();
    check_eq("t5_no_frame", 64'(fifo_level), 64'd0);
    check_eq("t5_no_valid", 64'(m_valid), 64'd0);
    aktv = '0;
    en = 1'b1;
    repeat (2) step();
    aktv = 9'b000000001;
    step();
    aktv = '0;
    wait_idle(40);
    check_eq("t5_ts", last_w0, 64'd5);

    // 6: reset during the third word of a four-word frame
    do_reset();
    en = 1'b1;
    repeat (2) step();
    set_val(1, 64'd11);
    set_val(4, 64'd44);
    aktv = 9'b000010010;
    step();
    aktv = '0;
    repeat (3) step();
    check_eq("t6_w2_shown", m_data, 64'd11);
    rst = 1'b1;
    step();
    check_eq("t6_valid_cleared", 64'(m_valid), 64'd0);
    check_eq("t6_level_cleared", 64'(fifo_level), 64'd0);
    rst = 1'b0;
    repeat (4) step();
    aktv = 9'b000000001;
    step();
    aktv = '0;
    wait_idle(40);
    check_eq("t6_ts", last_w0, 64'd4);
    check_eq("t6_seq", 64'(last_hdr[63:48]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/verdict_stream_serializer.md
Name: verdict_stream_serializer

Overview:
- Reader-side counterpart of the compiled monitor's output interface: samples the per-stream output values and `aktv` flags every cycle.
- Captures each cycle with at least one active output as a timestamped frame and buffers it.
- Emits frames as a ready/valid 64-bit word stream for an off-chip link or log sink.
- Sits directly after the monitor top, sharing its clock, reset and enable.

Parameters:
NUM_OUTPUTS, 9, number of monitor output streams (1..16)
DATA_W, 64, width of each output value (signed, <=64)
FIFO_DEPTH, 8, frames buffered (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
en  in  1  global enable, same signal the monitor receives
out_vals  in  NUM_OUTPUTS*DATA_W  packed values, stream i at bits [i*DATA_W +: DATA_W]
out_aktv  in  NUM_OUTPUTS  per-stream active flags
m_data  out  64  stream word
m_valid  out  1  word valid
m_last  out  1  last word of frame
m_ready  in  1  sink ready
overflow  out  1  sticky: at least one frame dropped since reset
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently buffered

Behaviour:
- Reset (sync, active-high):
  - m_valid=0, m_last=0, m_data=0, overflow=0, fifo_level=0.
  - Timestamp, sequence and drop counters cleared; FSM to IDLE; FIFO emptied.
  - Reset asserted mid-frame aborts the frame; m_valid=0 from the next cycle; no partial completion.
- Timestamp: 64-bit cycle counter, +1 per cycle with en=1, holds when en=0, wraps modulo 2^64.
- Capture:
  - Occurs on a rising edge where en=1 and out_aktv!=0.
  - Entry written: {timestamp, out_aktv, all out_vals, seq, drop_cnt}.
  - Values of inactive streams are stored but never emitted.
- Sequence and drop counters:
  - seq is 16 bits; increments per written frame; wraps.
  - drop_cnt is 16 bits, saturating at 0xFFFF. It is copied into the next written entry, then cleared on that write.
- Full rule: a capture while the FIFO is full (registered full flag) is dropped, even if a pop occurs in the same cycle. On a drop: drop_cnt+1, overflow<=1, seq unchanged.
- Frame format, words in order:
  - W0: timestamp.
  - W1 header: [15:0] aktv mask, zero-extended; [31:16] drop_cnt; [47:32] 0; [63:48] seq.
  - Then one word per set mask bit, ascending index, value sign-extended to 64.
  - m_last=1 on the final word only.
  - Frame length = 2 + popcount(mask).
- FSM:
  - IDLE -> TS when FIFO is non-empty (first-word-fall-through).
  - TS -> HDR on transfer.
  - HDR -> DATA on transfer.
  - In DATA: on transfer, if bits remain in the mask, select the next lowest set bit (priority encoder on the remaining mask); else pop the entry and go to IDLE.
  - From DATA, if another entry is ready on the last transfer, go directly to TS (back-to-back, no bubble).
- Latency: capture at edge E with FIFO empty -> m_valid=1 with W0 after edge E+1 (one full cycle later).
- Handshake:
  - Transfer when m_valid & m_ready.
  - While m_valid & !m_ready, m_data and m_last hold stable.
  - m_valid never drops without a transfer except on reset.
- en=0: no capture; serialization continues normally.
- fifo_level counts a frame until its last word transfers.

Decomposition:
- Shared package holds:
  - WORD_W=64, TS_W=64, SEQ_W=16, DROP_W=16.
  - Header field offsets.
  - Frame-entry struct typedef.
  - Function for the header word.
  - Lowest-set-bit priority function.
- One sub-module: verdict_frame_fifo, a synchronous FWFT FIFO of frame entries with registered full/empty and a level count.

Test Plan:
1. Single frame: after rst, 10 cycles with en=1; then aktv=9'b000000101, out0=7, out2=-3; m_ready=1 -> W0=10, W1=0x0000_0000_0000_0005, 7, 0xFFFF_FFFF_FFFF_FFFD with m_last; m_valid first high 2 edges after capture.
2. Backpressure: scenario 1 with m_ready=0 for 5 cycles on W1 -> W1 held stable with m_valid=1 throughout; stream order unchanged.
3. Full mask: aktv=0x1FF, outN=N+1 -> 11 words, values 1..9; m_last only on word 11.
4. Overflow: m_ready=0 and 10 consecutive capture cycles (depth 8) -> fifo_level=8, overflow=1. Then drain all and capture once more -> that frame's header has seq=8, drop=2.
5. Enable: en=0 for 4 cycles with aktv=0x001 -> no frames, timestamp frozen. After en=1, next frame's W0 equals the pre-stall count plus elapsed enabled cycles.
6. Reset mid-frame: assert rst during W2 of a 4-word frame -> m_valid=0 the next cycle, fifo_level=0. The next frame after reset has seq=0 and a timestamp counted from reset release.
